// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the accumulator CPU controller.
//   state_e   : 6-bit control state codes, also decoded by outputlogic
//   op_e      : 4-bit opcode field of IR byte0
//   am_e      : 2-bit addressing-mode field of IR byte0
//   is_mem_state  : states that wait on the memory handshake
//   operand_state : first operand-fetch state for an opcode/mode pair
package ctrl_pkg;

  typedef enum logic [5:0] {
    S_IDLE     = 6'd0,
    S_FETCH0   = 6'd1,
    S_FETCH1   = 6'd2,
    S_FETCH2   = 6'd3,
    S_FETCH3   = 6'd4,
    S_DECODE   = 6'd5,
    S_ALU      = 6'd6,
    S_LD_IMM   = 6'd7,
    S_ALU_IMM  = 6'd8,
    S_REGDIR   = 6'd9,
    S_MEMDIR   = 6'd10,
    S_MEMDIR2  = 6'd11,
    S_PCREL0   = 6'd12,
    S_PCREL1   = 6'd13,
    S_PCREL2   = 6'd14,
    S_PCREL3   = 6'd15,
    S_PCREL4   = 6'd16,
    S_ASR      = 6'd17,
    S_LSR      = 6'd18,
    S_ASL      = 6'd19,
    S_LSL      = 6'd20,
    S_JMP      = 6'd21,
    S_JZ       = 6'd22,
    S_JNZ      = 6'd23,
    S_POP      = 6'd24,
    S_PUSH     = 6'd25,
    S_STORE    = 6'd28,
    S_SHIFT_WB = 6'd29,
    S_ALU_WB   = 6'd30,
    S_HALT     = 6'd31,
    S_PCINC    = 6'd32
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_LOAD  = 4'd1,
    OP_ALU   = 4'd2,
    OP_STORE = 4'd3,
    OP_ASR   = 4'd4,
    OP_LSR   = 4'd5,
    OP_ASL   = 4'd6,
    OP_LSL   = 4'd7,
    OP_JMP   = 4'd8,
    OP_JZ    = 4'd9,
    OP_JNZ   = 4'd10,
    OP_POP   = 4'd11,
    OP_PUSH  = 4'd12,
    OP_RSV13 = 4'd13,
    OP_RSV14 = 4'd14,
    OP_HALT  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    AM_IMM    = 2'd0,
    AM_REGDIR = 2'd1,
    AM_MEMDIR = 2'd2,
    AM_PCREL  = 2'd3
  } am_e;

  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH0) || (s == S_FETCH1) || (s == S_FETCH2) ||
           (s == S_FETCH3) || (s == S_MEMDIR) || (s == S_PCREL3);
  endfunction

  // Immediate mode splits on opcode because LOAD finishes without an ALU pass.
  function automatic state_e operand_state(input op_e op, input am_e am);
    state_e s;
    s = S_ALU_IMM;
    case (am)
      AM_IMM:    s = (op == OP_LOAD) ? S_LD_IMM : S_ALU_IMM;
      AM_REGDIR: s = S_REGDIR;
      AM_MEMDIR: s = S_MEMDIR;
      AM_PCREL:  s = S_PCREL0;
      default:   s = S_ALU_IMM;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: datapath <-> sequencer signal bundle.
//   master : datapath side, drives fetch_byte/mem_ready/opcode/amode/zero
//   slave  : sequencer side, drives state/halted/bus_error/instr_count
interface control_sequencer_if #(
  parameter int CNT_W = 16
) ();
  logic [7:0]       fetch_byte;
  logic             mem_ready;
  logic [3:0]       opcode;
  logic [1:0]       amode;
  logic             zero;
  logic [5:0]       state;
  logic             halted;
  logic             bus_error;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output fetch_byte, mem_ready, opcode, amode, zero,
    input  state, halted, bus_error, instr_count
  );

  modport slave (
    input  fetch_byte, mem_ready, opcode, amode, zero,
    output state, halted, bus_error, instr_count
  );
endinterface

// File: rtl/wait_timer.sv
// wait_timer: counts cycles a memory state has been held waiting.
//   clk, reset_n : clock, async active-low reset
//   en           : count one more held cycle
//   clr          : return to zero (has priority over en)
//   expired      : count has reached WAIT_LIMIT
module wait_timer #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic expired
);
  logic [7:0] cnt_q;

  assign expired = (cnt_q == WAIT_LIMIT[7:0]);

  // Saturates at the limit; the sequencer leaves the memory state on that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
    end else if (clr) begin
      cnt_q <= 8'd0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: next-state half of the multicycle accumulator CPU controller.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : fetch_byte/mem_ready/opcode/amode/zero in;
//                  state (flop output), halted (state==31), bus_error (sticky),
//                  instr_count (retired instructions, wraps) out
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int WAIT_LIMIT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  control_sequencer_if.slave   bus
);
  state_e           state_q, state_d;
  logic [1:0]       len_q;
  logic             bus_error_q;
  logic [CNT_W-1:0] count_q;
  logic             waiting, expired, set_error, retire;
  op_e              op;
  am_e              am;

  assign op      = op_e'(bus.opcode);
  assign am      = am_e'(bus.amode);
  assign waiting = is_mem_state(state_q) && !bus.mem_ready;

  wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (waiting),
    .clr     (!waiting),
    .expired (expired)
  );

  // State, fetch length, error flag and retire counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      len_q       <= 2'd0;
      bus_error_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH0 && bus.mem_ready) len_q <= bus.fetch_byte[7:6];
      if (set_error) bus_error_q <= 1'b1;
      if (retire) count_q <= count_q + 1'b1;
    end
  end

  // Next state. A stalled memory state holds, or aborts to halt on timeout;
  // mem_ready on the limit cycle takes the normal path.
  always_comb begin
    state_d   = state_q;
    set_error = 1'b0;
    if (waiting) begin
      if (expired) begin
        state_d   = S_HALT;
        set_error = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_FETCH0;
        S_FETCH0: state_d = (bus.fetch_byte[7:6] != 2'd0) ? S_FETCH1 : S_DECODE;
        S_FETCH1: state_d = (len_q >= 2'd2) ? S_FETCH2 : S_DECODE;
        S_FETCH2: state_d = (len_q == 2'd3) ? S_FETCH3 : S_DECODE;
        S_FETCH3: state_d = S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD:  state_d = operand_state(op, am);
            OP_ALU:   state_d = S_ALU;
            OP_STORE: state_d = S_STORE;
            OP_ASR:   state_d = S_ASR;
            OP_LSR:   state_d = S_LSR;
            OP_ASL:   state_d = S_ASL;
            OP_LSL:   state_d = S_LSL;
            OP_JMP:   state_d = S_JMP;
            OP_JZ:    state_d = S_JZ;
            OP_JNZ:   state_d = S_JNZ;
            OP_POP:   state_d = S_POP;
            OP_PUSH:  state_d = S_PUSH;
            OP_HALT:  state_d = S_HALT;
            default:  state_d = S_PCINC;
          endcase
        end
        S_ALU:      state_d = operand_state(op, am);
        S_LD_IMM:   state_d = S_PCINC;
        S_ALU_IMM:  state_d = S_ALU_WB;
        S_REGDIR:   state_d = S_ALU_WB;
        S_MEMDIR:   state_d = S_MEMDIR2;
        S_MEMDIR2:  state_d = S_ALU_WB;
        S_PCREL0:   state_d = S_PCREL1;
        S_PCREL1:   state_d = S_PCREL2;
        S_PCREL2:   state_d = S_PCREL3;
        S_PCREL3:   state_d = S_PCREL4;
        S_PCREL4:   state_d = (op == OP_LOAD) ? S_PCINC : S_ALU_WB;
        S_ASR, S_LSR, S_ASL, S_LSL: state_d = S_SHIFT_WB;
        S_SHIFT_WB: state_d = S_PCINC;
        S_ALU_WB:   state_d = S_PCINC;
        S_POP, S_PUSH, S_STORE: state_d = S_PCINC;
        S_PCINC:    state_d = S_FETCH0;
        S_JMP:      state_d = S_FETCH0;
        S_JZ:       state_d = bus.zero ? S_FETCH0 : S_PCINC;
        S_JNZ:      state_d = bus.zero ? S_PCINC : S_FETCH0;
        S_HALT:     state_d = S_HALT;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // An instruction retires when control returns to fetch; the first fetch
  // after reset comes from idle and is not counted.
  assign retire = (state_d == S_FETCH0) &&
                  ((state_q == S_PCINC) || (state_q == S_JMP) ||
                   (state_q == S_JZ) || (state_q == S_JNZ));

  assign bus.state       = state_q;
  assign bus.halted      = (state_q == S_HALT);
  assign bus.bus_error   = bus_error_q;
  assign bus.instr_count = count_q;
endmodule
